// File: rtl/modulo_demux_pkg.sv
// modulo_demux_pkg: shared state encoding and slot constants for the 1:8 TDM demux
package modulo_demux_pkg;
    localparam int SLOTS  = 8;
    localparam int SLOT_W = $clog2(SLOTS);
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;
endpackage

// File: rtl/modulo_decoder3_8.sv
// modulo_decoder3_8: 3-bit binary select to one-hot 8 write enable
module modulo_decoder3_8
    import modulo_demux_pkg::*;
(
    input  logic [SLOT_W-1:0] sel,
    output logic [SLOTS-1:0]  onehot
);
    assign onehot = {{(SLOTS-1){1'b0}}, 1'b1} << sel;
endmodule

// File: rtl/modulo_demux1_8_tdm.sv
// modulo_demux1_8_tdm: serial TDM frame or direct-addressed 1:8 demux with registered outputs
module modulo_demux1_8_tdm
    import modulo_demux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic       in_valid,
    input  logic       frame_start,
    input  logic       mode,
    input  logic [2:0] input_sel,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       H,
    output logic       frame_valid,
    output logic       busy,
    output logic       frame_err
);
    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d, sel;
    logic [SLOTS-1:0]  shadow_q, shadow_d, out_q, out_d, wen, merged;
    logic              fv_q, fv_d, fe_q, fe_d, busy_q, busy_d, start;

    assign start = in_valid & frame_start;
    // a restart always lands in slot 0, even mid-frame
    assign sel   = mode ? input_sel : (start ? '0 : slot_q);

    modulo_decoder3_8 u_dec (
        .sel    (sel),
        .onehot (wen)
    );

    assign merged = (shadow_q & ~wen) | (wen & {SLOTS{in}});

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        if (mode) begin
            if (state_q == RECV) begin
                fe_d    = 1'b1;
                state_d = IDLE;
                slot_d  = '0;
            end
            if (in_valid) out_d = (out_q & ~wen) | (wen & {SLOTS{in}});
        end else if (start) begin
            fe_d     = (state_q == RECV);
            shadow_d = merged;
            slot_d   = SLOT_W'(1);
            state_d  = RECV;
        end else if (state_q == RECV && in_valid) begin
            shadow_d = merged;
            slot_d   = slot_q + SLOT_W'(1);
            if (slot_q == SLOT_W'(SLOTS - 1)) begin
                out_d   = merged;
                state_d = IDLE;
                fv_d    = 1'b1;
            end
        end
        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            busy_q   <= busy_d;
        end
    end

    assign {H, G, F, E, D, C, B, A} = out_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_modulo_demux1_8_tdm.sv
// tb_modulo_demux1_8_tdm: directed self-checking bench for the 1:8 TDM demux
module tb_modulo_demux1_8_tdm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in = 1'b0, in_valid = 1'b0, frame_start = 1'b0, mode = 1'b0;
    logic [2:0] input_sel = 3'd0;
    logic       A, B, C, D, E, F, G, H, frame_valid, busy, frame_err;
    logic [7:0] outs;
    int         vectors = 0;
    int         miscompares = 0;

    assign outs = {H, G, F, E, D, C, B, A};

    modulo_demux1_8_tdm dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .frame_start(frame_start),
        .mode(mode), .input_sel(input_sel), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
        .G(G), .H(H), .frame_valid(frame_valid), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // drive at a negedge, let one posedge pass, return at the next negedge
    task automatic cyc(input logic v, input logic b, input logic fs);
        in_valid = v; in = b; frame_start = fs;
        @(negedge clk);
        in_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (outs !== 8'h00) begin miscompares++; $display("FAIL reset_outs: got %h expected 00", outs); end
        vectors++; if ({frame_valid, frame_err, busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {frame_valid, frame_err, busy}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vectors++; if ({outs, busy} !== 9'h000) begin miscompares++; $display("FAIL reset_hold: got %h expected 000", {outs, busy}); end
    endtask

    task automatic test_idle_ignore;
        cyc(1'b1, 1'b1, 1'b0);
        vectors++; if ({busy, outs} !== 9'h000) begin miscompares++; $display("FAIL idle_valid_no_start: got %h expected 000", {busy, outs}); end
        cyc(1'b0, 1'b1, 1'b1);
        vectors++; if ({busy, outs} !== 9'h000) begin miscompares++; $display("FAIL start_no_valid: got %h expected 000", {busy, outs}); end
    endtask

    task automatic test_frame;
        logic [7:0] bits;
        bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, bits[i], i == 0);
            if (i < 7) begin
                vectors++; if ({busy, frame_valid, outs} !== 10'b10_0000_0000) begin miscompares++; $display("FAIL frame_mid slot%0d: got %b expected 1000000000", i, {busy, frame_valid, outs}); end
            end
        end
        vectors++; if (outs !== 8'h4D) begin miscompares++; $display("FAIL frame_outs: got %h expected 4d", outs); end
        vectors++; if ({frame_valid, busy, frame_err} !== 3'b100) begin miscompares++; $display("FAIL frame_flags: got %b expected 100", {frame_valid, busy, frame_err}); end
        cyc(1'b0, 1'b0, 1'b0);
        vectors++; if ({frame_valid, busy, outs} !== 10'h04D) begin miscompares++; $display("FAIL frame_after: got %h expected 04d", {frame_valid, busy, outs}); end
    endtask

    task automatic test_restart;
        int fe_cnt, fv_cnt;
        fe_cnt = 0; fv_cnt = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, ~i[0], i == 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, i == 0);
            fe_cnt += int'(frame_err); fv_cnt += int'(frame_valid);
            if (i == 0) begin
                vectors++; if ({frame_err, frame_valid, busy} !== 3'b101) begin miscompares++; $display("FAIL restart_err: got %b expected 101", {frame_err, frame_valid, busy}); end
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        fe_cnt += int'(frame_err); fv_cnt += int'(frame_valid);
        vectors++; if (outs !== 8'hFF) begin miscompares++; $display("FAIL restart_outs: got %h expected ff", outs); end
        vectors++; if (fe_cnt !== 1 || fv_cnt !== 1) begin miscompares++; $display("FAIL restart_pulses: got err=%0d valid=%0d expected 1/1", fe_cnt, fv_cnt); end
    endtask

    task automatic test_restart_slot7;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, i == 0);
        cyc(1'b1, 1'b1, 1'b1);
        vectors++; if ({frame_err, frame_valid, busy, outs} !== 11'b101_1111_1111) begin miscompares++; $display("FAIL slot7_restart: got %b expected 10111111111", {frame_err, frame_valid, busy, outs}); end
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0);
        vectors++; if ({frame_valid, frame_err, outs} !== 10'b10_0000_0001) begin miscompares++; $display("FAIL slot7_frame: got %b expected 1000000001", {frame_valid, frame_err, outs}); end
    endtask

    task automatic test_gaps;
        logic [7:0] bits;
        bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, bits[i], i == 0);
            if (i == 2 || i == 5) begin
                cyc(1'b0, 1'b1, 1'b0);
                vectors++; if ({busy, frame_valid, outs} !== 10'b10_0000_0001) begin miscompares++; $display("FAIL gap slot%0d: got %b expected 1000000001", i, {busy, frame_valid, outs}); end
            end
        end
        vectors++; if ({frame_valid, busy, outs} !== 10'b10_0100_1101) begin miscompares++; $display("FAIL gap_frame: got %b expected 1001001101", {frame_valid, busy, outs}); end
    endtask

    task automatic test_direct;
        mode = 1'b1;
        input_sel = 3'b101; cyc(1'b1, 1'b1, 1'b0);
        vectors++; if ({frame_valid, busy, outs} !== 10'h06D) begin miscompares++; $display("FAIL direct_F: got %h expected 06d", {frame_valid, busy, outs}); end
        input_sel = 3'b000; cyc(1'b1, 1'b0, 1'b0);
        vectors++; if (outs !== 8'h6C) begin miscompares++; $display("FAIL direct_A: got %h expected 6c", outs); end
        input_sel = 3'b111; cyc(1'b1, 1'b1, 1'b1);
        vectors++; if ({frame_valid, frame_err, busy, outs} !== 11'h0EC) begin miscompares++; $display("FAIL direct_H: got %h expected 0ec", {frame_valid, frame_err, busy, outs}); end
        input_sel = 3'b010; cyc(1'b0, 1'b1, 1'b0);
        vectors++; if (outs !== 8'hEC) begin miscompares++; $display("FAIL direct_novalid: got %h expected ec", outs); end
        mode = 1'b0;
    endtask

    task automatic test_mode_switch;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, i == 0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL switch_busy: got %b expected 1", busy); end
        mode = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        vectors++; if ({frame_err, frame_valid, busy, outs} !== 11'h4EC) begin miscompares++; $display("FAIL switch_err: got %h expected 4ec", {frame_err, frame_valid, busy, outs}); end
        cyc(1'b0, 1'b0, 1'b0);
        vectors++; if ({frame_err, busy, outs} !== 10'h0EC) begin miscompares++; $display("FAIL switch_after: got %h expected 0ec", {frame_err, busy, outs}); end
        mode = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] bits;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i == 0);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({outs, busy, frame_valid, frame_err} !== 11'h000) begin miscompares++; $display("FAIL midreset_async: got %h expected 000", {outs, busy, frame_valid, frame_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        bits = 8'b1010_1010;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, bits[i], i == 0);
            if (i == 0) begin
                vectors++; if ({frame_err, busy} !== 2'b01) begin miscompares++; $display("FAIL midreset_first: got %b expected 01", {frame_err, busy}); end
            end
        end
        vectors++; if ({frame_valid, frame_err, outs} !== 10'b10_1010_1010) begin miscompares++; $display("FAIL midreset_frame: got %b expected 1010101010", {frame_valid, frame_err, outs}); end
    endtask

    initial begin
        test_reset;
        test_idle_ignore;
        test_frame;
        test_restart;
        test_restart_slot7;
        test_gaps;
        test_direct;
        test_mode_switch;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
